// File: rtl/rr_otf_convert_pkg.sv
// Shared definitions for the radix-R on-the-fly converter: state encoding and
// derived-width helpers so every file computes D, K, RW and the counter width identically.
package rr_otf_convert_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } otf_state_t;

    function automatic int digit_bits(input int radix);
        return $clog2(radix) + 1;
    endfunction

    function automatic int shift_bits(input int radix);
        return $clog2(radix);
    endfunction

    function automatic int result_bits(input int radix, input int width);
        return width * $clog2(radix) + 1;
    endfunction

    function automatic int count_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/rr_otf_convert_if.sv
// Digit-in / word-out handshake bundle for rr_otf_convert. The master side feeds
// signed digits and takes completed words; the slave side is the converter.
interface rr_otf_convert_if
    import rr_otf_convert_pkg::*;
#(
    parameter int RADIX = 4,
    parameter int WIDTH = 4
);
    localparam int D  = digit_bits(RADIX);
    localparam int RW = result_bits(RADIX, WIDTH);

    logic          in_valid;
    logic          in_ready;
    logic [D-1:0]  p_in;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] result;
    logic          dig_err;

    modport master (
        output in_valid, p_in, out_ready,
        input  in_ready, out_valid, result, dig_err
    );

    modport slave (
        input  in_valid, p_in, out_ready,
        output in_ready, out_valid, result, dig_err
    );

endinterface

// File: rtl/rr_otf_convert_append.sv
// Combinational Q/QM append step: shifts one signed digit into the pair of
// candidate words, keeping QM == Q-1 so no carry-propagate adder is ever needed.
module rr_otf_convert_append
    import rr_otf_convert_pkg::*;
#(
    parameter int RADIX = 4,
    parameter int WIDTH = 4,
    localparam int D  = digit_bits(RADIX),
    localparam int K  = shift_bits(RADIX),
    localparam int RW = result_bits(RADIX, WIDTH)
) (
    input  logic [RW-1:0] q,
    input  logic [RW-1:0] qm,
    input  logic [D-1:0]  p,
    output logic [RW-1:0] q_next,
    output logic [RW-1:0] qm_next,
    output logic          illegal
);

    // -R is the only D-bit pattern outside the digit set.
    localparam logic [D-1:0] ILLEGAL_DIGIT = D'(1) << K;

    logic          neg;
    logic          zero;
    logic [K-1:0]  mag;
    logic [K-1:0]  q_digit;
    logic [K-1:0]  qm_digit;
    logic [RW-1:0] q_src;
    logic [RW-1:0] qm_src;

    always_comb begin
        illegal = (p == ILLEGAL_DIGIT);
        neg     = p[D-1];
        zero    = (p == '0);

        // An illegal digit is treated as -(R-1) so the word still completes.
        if (illegal)
            mag = K'(RADIX - 1);
        else if (neg)
            mag = K'(-p);
        else
            mag = p[K-1:0];

        q_digit  = neg ? -mag : mag;
        qm_digit = neg ? ~mag : mag - 1'b1;

        q_src  = neg ? qm : q;
        qm_src = (neg || zero) ? qm : q;

        q_next  = RW'({q_src, q_digit});
        qm_next = RW'({qm_src, qm_digit});
    end

endmodule

// File: rtl/rr_otf_convert.sv
// On-the-fly MSDF signed-digit to two's-complement converter: FSM, digit counter,
// Q/QM registers and the valid/ready handshakes around rr_otf_convert_append.
module rr_otf_convert
    import rr_otf_convert_pkg::*;
#(
    parameter int RADIX = 4,
    parameter int WIDTH = 4,
    localparam int D  = digit_bits(RADIX),
    localparam int RW = result_bits(RADIX, WIDTH),
    localparam int CW = count_bits(WIDTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    rr_otf_convert_if.slave     bus
);

    otf_state_t    state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] q;
    logic [RW-1:0] qm;
    logic [RW-1:0] q_next;
    logic [RW-1:0] qm_next;
    logic [RW-1:0] result;
    logic          err_acc;
    logic          dig_err;
    logic          out_valid;
    logic          illegal;
    logic          accept;
    logic          take;
    logic          last;
    logic [D-1:0]  digit;

    assign digit         = bus.p_in;
    assign bus.in_ready  = (state != DONE) | bus.out_ready;
    assign accept        = bus.in_valid & bus.in_ready;
    assign take          = out_valid & bus.out_ready;
    assign last          = (cnt == CW'(WIDTH - 1));

    assign bus.out_valid = out_valid;
    assign bus.result    = result;
    assign bus.dig_err   = dig_err;

    rr_otf_convert_append #(
        .RADIX (RADIX),
        .WIDTH (WIDTH)
    ) u_append (
        .q       (q),
        .qm      (qm),
        .p       (digit),
        .q_next  (q_next),
        .qm_next (qm_next),
        .illegal (illegal)
    );

    // Take is handled first so a same-cycle accept can restart ACC/DONE on top of it;
    // clear then overrides accept but leaves a finished word in DONE untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            q         <= '0;
            qm        <= '1;
            err_acc   <= 1'b0;
            result    <= '0;
            dig_err   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (take) begin
                out_valid <= 1'b0;
                state     <= IDLE;
            end

            if (clear) begin
                q       <= '0;
                qm      <= '1;
                cnt     <= '0;
                err_acc <= 1'b0;
                if (state != DONE)
                    state <= IDLE;
            end else if (accept) begin
                if (last) begin
                    result    <= q_next;
                    dig_err   <= err_acc | illegal;
                    out_valid <= 1'b1;
                    state     <= DONE;
                    q         <= '0;
                    qm        <= '1;
                    cnt       <= '0;
                    err_acc   <= 1'b0;
                end else begin
                    q       <= q_next;
                    qm      <= qm_next;
                    cnt     <= cnt + 1'b1;
                    err_acc <= err_acc | illegal;
                    state   <= ACC;
                end
            end
        end
    end

endmodule
